prio_req_encoder: RTL

- Parametrised, registered N-input priority encoder for request/interrupt lines.
- Latches request pulses into a pending register and presents one encoded winner at a time on a valid/ack handshake.
- Supports fixed-priority or round-robin selection.
- Sits between peripheral request sources and the control logic that services them, for example interrupt cause selection.

---
 rtl/prio_req_encoder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/prio_req_encoder.sv
// prio_req_encoder: registered N-input priority encoder.
// Request pulses are latched into a pending register. One winner at a time
// is presented on out_idx under a valid/ack handshake. The winner is chosen by
// fixed priority (highest index) or by round-robin from the last accepted index.
//
// Handshake: out_valid=1 means out_idx holds a winner that stays stable until
// an edge where out_ack=1 (and clr_all=0). That edge clears pending[out_idx]
// and drops out_valid. At least one out_valid=0 cycle follows before the next
// grant. out_ack is ignored while out_valid=0.
module prio_req_encoder #(
  parameter int N       = 8,
  parameter int RR_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic                 clr_all,
  input  logic                 out_ack,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 any_pending,
  output logic [N-1:0]         pending,
  output logic                 dbg_state_o
);

  localparam int W = $clog2(N);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [W-1:0]   last_q, last_d;

  logic [N-1:0]   eligible;
  logic [N-1:0]   clr_mask;
  logic           ack_fire;
  logic [W-1:0]   sel_idx;
  logic           sel_found;

  assign eligible = pending_q & mask;

  // An ack only counts while a grant is held; clr_all overrides it.
  assign ack_fire = (state_q == S_GRANT) && out_ack && !clr_all;
  assign clr_mask = ack_fire ? (N'(1) << idx_q) : '0;

  // Winner selection among eligible lines.
  always_comb begin
    int j;
    sel_idx   = '0;
    sel_found = 1'b0;
    j         = 0;
    if (RR_MODE == 0) begin
      // Ascending scan; the last hit is the highest set index.
      for (int i = 0; i < N; i++) begin
        if (eligible[W'(i)]) begin
          sel_idx   = W'(i);
          sel_found = 1'b1;
        end
      end
    end else begin
      // Scan offsets from farthest to nearest so the last hit is the first
      // set bit at or after (last+1) mod N in wrapping ascending order.
      for (int k = N; k >= 1; k--) begin
        j = int'(last_q) + k;
        if (j >= N) j = j - N;
        if (eligible[W'(j)]) begin
          sel_idx   = W'(j);
          sel_found = 1'b1;
        end
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      last_q    <= W'(N - 1);
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
    end
  end

  // Next-state logic: grant when something is eligible, release on ack or clear.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    // Clearing before OR-ing req lets a same-cycle request survive its own ack.
    pending_d = (pending_q & ~clr_mask) | req;
    if (clr_all) begin
      state_d   = S_IDLE;
      pending_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_found) begin
            state_d = S_GRANT;
            idx_d   = sel_idx;
          end
        end
        S_GRANT: begin
          if (ack_fire) begin
            state_d = S_IDLE;
            last_d  = idx_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs come straight from registers; any_pending ignores the live req.
  always_comb begin
    out_valid   = (state_q == S_GRANT);
    out_idx     = idx_q;
    pending     = pending_q;
    any_pending = |eligible;
    dbg_state_o = state_q;
  end

endmodule
